butterfly_output_serializer: RTL and testbench
==============================================

// Module: butterfly_output_serializer
// PURPOSE
//  Consumer end of the butterfly output interface. Accepts {X,Y} complex_product_t pairs qualified by
//  the butterfly out_valid, rescales each component back to complex_t (round + saturate), buffers pairs
//  in a small FIFO and emits a single-sample valid/ready stream, X then Y. in_ready drives the upstream
//  butterfly enable, so the stage stalls instead of dropping results.
// PARAMETERS
//  DATA_W  16  width of each complex_t component (signed)
//  PROD_W  32  width of each complex_product_t component (signed)
//  SHIFT   15  right shift applied on rescale (product fractional bits minus sample fractional bits)
//  DEPTH   4   FIFO depth in {X,Y} pairs; power of two, >= 2
// PORTS
//  clk        in   1                 clock; all logic on posedge
//  reset      in   1                 synchronous, active-high
//  in_valid   in   1                 pair valid (from butterfly out_valid)
//  X          in   2*PROD_W          complex_product_t, butterfly X output
//  Y          in   2*PROD_W          complex_product_t, butterfly Y output
//  in_ready   out  1                 FIFO can accept a pair (to butterfly enable)
//  out_valid  out  1                 out_data valid
//  out_ready  in   1                 downstream accepts out_data
//  out_data   out  2*DATA_W          complex_t, rescaled sample
//  out_last   out  1                 1 when out_data is the Y of its pair
//  clr_sat    in   1                 clears sat_seen
//  sat_seen   out  1                 sticky: some component saturated since reset/clr_sat
//  level      out  $clog2(DEPTH)+1   pairs currently held (incl. pair being sent)
// BEHAVIOUR
//  Interface: one clock clk; reset synchronous, active-high.
//  Reset: out_valid=0, out_data=0, out_last=0, sat_seen=0, level=0, FIFO pointers 0, FSM=IDLE;
//   in_ready=1 the cycle after reset deasserts. Reset mid-transfer discards all buffered pairs.
//  Push: when in_valid && in_ready; in_ready = (level < DEPTH), from registered level only (no
//   same-cycle pop bypass). in_valid while !in_ready is ignored; no data is written.
//  Rescale (per r and i, at push): t = v + 2^(SHIFT-1) (PROD_W+1 bits, no wrap); q = t >>> SHIFT;
//   q > 2^(DATA_W-1)-1 -> 2^(DATA_W-1)-1; q < -2^(DATA_W-1) -> -2^(DATA_W-1); else q.
//   Any clamp on a pushed pair sets sat_seen next cycle. Clamp and clr_sat same cycle -> sat_seen=1.
//  FSM: IDLE -> SEND_X when level>0; SEND_X: out_valid=1, out_data=head.X, out_last=0;
//   on out_ready -> SEND_Y. SEND_Y: out_data=head.Y, out_last=1; on out_ready pop head,
//   then SEND_X if level-1>0 else IDLE. out_data/out_last stable while out_valid && !out_ready.
//  Latency: pair pushed at edge t into empty FIFO -> X presented on out_data after edge t+1.
//   Back-to-back with out_ready=1: one sample per cycle, no bubble between pairs.
//  Simultaneous push and pop: level unchanged; FIFO full at that cycle still blocks push.
//  Pointers wrap modulo DEPTH; level never exceeds DEPTH and never underflows.
// TESTING
//  1 Reset, push X=(3<<15, -(3<<15)), Y=(0xC000, 0x4000), out_ready=1 -> 0x0003/0xFFFD, then
//    0x0002/0x0001 with out_last=0,1; sat_seen=0; level returns 0.
//  2 Push X.r=0x7FFFFFFF, X.i=0x80000000 -> out 0x7FFF/0x8000, sat_seen=1; clr_sat pulse -> 0.
//  3 Rounding: X.r=-0x4000 -> 0x0000; X.r=-0x4001 -> 0xFFFF; X.r=0x3FFF -> 0x0000.
//  4 out_ready=0, push 5 pairs every cycle -> 4 accepted, in_ready=0, level=4; then out_ready=1
//    -> 8 samples in push order, contiguous, in_ready rises after first Y handshake.
//  5 Random out_ready stalls over 64 pairs vs golden model -> no loss/duplication, data held
//    stable while stalled, out_last alternates 0,1.
//  6 Assert reset in SEND_Y with level=3 -> next cycle out_valid=0, level=0, in_ready=1.

Source files
------------

// File: rtl/butterfly_output_serializer.sv
// Rescales butterfly {X,Y} product pairs to complex samples and serializes them X then Y.
// Latency: a pair pushed into an empty buffer shows its X on out_data one cycle later.
// Backpressure: in_ready drops when DEPTH pairs are held; out_valid holds data stable until out_ready.

module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push_vld && (count != FULL_CNT);
    assign pop_ok   = pop_rdy && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module butterfly_output_serializer #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int SHIFT  = 15,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [2*PROD_W-1:0]         X,
    input  logic [2*PROD_W-1:0]         Y,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*DATA_W-1:0]         out_data,
    output logic                        out_last,
    input  logic                        clr_sat,
    output logic                        sat_seen,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_X = 2'd1;
    localparam logic [1:0] SEND_Y = 2'd2;

    localparam logic signed [PROD_W:0] ONE    = {{PROD_W{1'b0}}, 1'b1};
    localparam logic signed [PROD_W:0] RND    = ONE <<< (SHIFT-1);
    localparam logic signed [PROD_W:0] SAT_HI = (ONE <<< (DATA_W-1)) - ONE;
    localparam logic signed [PROD_W:0] SAT_LO = -SAT_HI - ONE;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] i;
    } cplx_t;

    typedef struct packed {
        cplx_t x;
        cplx_t y;
    } pair_t;

    // Returns {clamped, sample}; the add is one bit wider so the rounding offset cannot wrap.
    function automatic logic [DATA_W:0] rescale(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W:0] t;
        logic signed [PROD_W:0] q;
        t = {v[PROD_W-1], v} + RND;
        q = t >>> SHIFT;
        if (q > SAT_HI)      return {1'b1, SAT_HI[DATA_W-1:0]};
        else if (q < SAT_LO) return {1'b1, SAT_LO[DATA_W-1:0]};
        else                 return {1'b0, q[DATA_W-1:0]};
    endfunction

    logic [1:0] state;
    pair_t      push_pair_dat;
    pair_t      head;
    logic       sat_xr, sat_xi, sat_yr, sat_yi;
    logic       push_vld;
    logic       pop_rdy;

    always_comb begin
        push_pair_dat = '0;
        {sat_xr, push_pair_dat.x.r} = rescale(X[2*PROD_W-1:PROD_W]);
        {sat_xi, push_pair_dat.x.i} = rescale(X[PROD_W-1:0]);
        {sat_yr, push_pair_dat.y.r} = rescale(Y[2*PROD_W-1:PROD_W]);
        {sat_yi, push_pair_dat.y.i} = rescale(Y[PROD_W-1:0]);
    end

    assign in_ready = (level != FULL_CNT);
    assign push_vld = in_valid && in_ready;
    assign pop_rdy  = (state == SEND_Y) && out_ready;

    sync_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_pair_dat),
        .pop_rdy  (pop_rdy),
        .head_dat (head),
        .count    (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (level != '0) state <= SEND_X;
                SEND_X:  if (out_ready) state <= SEND_Y;
                SEND_Y:  if (out_ready) state <= (level > CNT_ONE) ? SEND_X : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A clamp on the pushed pair outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_seen <= 1'b0;
        end else if (push_vld && (sat_xr || sat_xi || sat_yr || sat_yi)) begin
            sat_seen <= 1'b1;
        end else if (clr_sat) begin
            sat_seen <= 1'b0;
        end
    end

    always_comb begin
        out_data = '0;
        if (state == SEND_X)      out_data = head.x;
        else if (state == SEND_Y) out_data = head.y;
    end

    assign out_valid = (state != IDLE);
    assign out_last  = (state == SEND_Y);
endmodule

// File: tb/tb_butterfly_output_serializer.sv
// Directed bench for butterfly_output_serializer with a scoreboard on the output stream.
module tb_butterfly_output_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] X = '0;
    logic [63:0] Y = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        clr_sat = 1'b0;
    logic        sat_seen;
    logic [2:0]  level;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rdy_mode = 1;    // 0: always ready, 1: hold off, 2: random
    logic [31:0] exp_x = '0;
    logic [31:0] exp_y = '0;
    logic [32:0] exp_q[$];
    int          n_in = 0;
    int          n_out = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;

    butterfly_output_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .clr_sat   (clr_sat),
        .sat_seen  (sat_seen),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_v(input logic [15:0] s, input int off);
        int v;
        v = int'($signed(s)) * 32768 + off;
        return v;
    endfunction

    task automatic push(input logic [31:0] xr, input logic [31:0] xi,
                        input logic [31:0] yr, input logic [31:0] yi,
                        input logic [31:0] ex, input logic [31:0] ey);
        in_valid = 1'b1;
        X = {xr, xi};
        Y = {yr, yi};
        exp_x = ex;
        exp_y = ey;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_timeout", (i < 400) ? 64'd1 : 64'd0, 64'd1);
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Output monitor: owns out_ready, scoreboards handshakes, checks hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            out_ready = 1'b0;
            prev_stall = 1'b0;
        end else begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_dat", out_data, prev_dat);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[31:0]);
                    chk("out_last", out_last, e[32]);
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, exp_x});
                exp_q.push_back({1'b1, exp_y});
                n_in++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_in;
        int base_out;
        int k;
        int wait_cnt;
        logic acc;
        logic [15:0] s[4];

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat_seen", sat_seen, 0);
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();

        // Basic pair, latency and rounding of exact values
        rdy_mode = 0;
        push(32'h0001_8000, 32'hFFFE_8000, 32'h0000_C000, 32'h0000_4000,
             32'h0003_FFFD, 32'h0002_0001);
        @(negedge clk);
        chk("lat_idle_vld", out_valid, 0);
        chk("lat_level", level, 1);
        @(negedge clk);
        chk("lat_x_vld", out_valid, 1);
        chk("lat_x_dat", out_data, 32'h0003_FFFD);
        chk("lat_x_last", out_last, 0);
        tick();
        drain();
        chk("t1_sat", sat_seen, 0);
        chk("t1_level", level, 0);

        // Saturation, clamp wins over a simultaneous clear, then clear
        clr_sat = 1'b1;
        push(32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 32'h7FFF_8000, 32'h0);
        clr_sat = 1'b0;
        @(negedge clk);
        chk("sat_set", sat_seen, 1);
        tick();
        drain();
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        @(negedge clk);
        chk("sat_clr", sat_seen, 0);
        tick();

        // Rounding around the half-LSB
        push(32'hFFFF_C000, 32'hFFFF_BFFF, 32'h0000_3FFF, 32'h0000_4000,
             32'h0000_FFFF, 32'h0000_0001);
        drain();
        chk("round_sat", sat_seen, 0);

        // Fill to full with output stalled, then burst out
        rdy_mode = 1;
        base_in = n_in;
        for (k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            X = {32'(k) << 15, 32'(k + 10) << 15};
            Y = {32'(k + 20) << 15, 32'(k + 30) << 15};
            exp_x = {16'(k), 16'(k + 10)};
            exp_y = {16'(k + 20), 16'(k + 30)};
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_level", level, 4);
        chk("full_accepted", n_in - base_in, 4);
        tick();
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("burst_vld", out_valid, 1);
            if (i == 1) chk("burst_rdy_before_pop", in_ready, 0);
            if (i == 2) chk("burst_rdy_after_pop", in_ready, 1);
        end
        @(negedge clk);
        chk("burst_end_vld", out_valid, 0);
        tick();
        drain();

        // Random stalls over 64 pairs
        rdy_mode = 2;
        base_in = n_in;
        base_out = n_out;
        for (k = 0; k < 64; k++) begin
            int off[4];
            for (int j = 0; j < 4; j++) begin
                s[j] = 16'($urandom_range(0, 65535));
                off[j] = int'($urandom_range(0, 32767)) - 16384;
            end
            X = {make_v(s[0], off[0]), make_v(s[1], off[1])};
            Y = {make_v(s[2], off[2]), make_v(s[3], off[3])};
            exp_x = {s[0], s[1]};
            exp_y = {s[2], s[3]};
            in_valid = 1'b1;
            wait_cnt = 0;
            do begin
                acc = in_ready;
                tick();
                wait_cnt++;
            end while (!acc && wait_cnt < 200);
            in_valid = 1'b0;
            if (!acc) chk("rand_push_timeout", in_ready, 1);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        chk("rand_pairs_in", n_in - base_in, 64);
        chk("rand_samples_out", n_out - base_out, 128);

        // Reset while sending Y with three pairs held
        rdy_mode = 1;
        push(32'h0000_8000, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0);
        push(32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0002_0000, 32'h0);
        push(32'h0001_8000, 32'h0, 32'h0, 32'h0, 32'h0003_0000, 32'h0);
        rdy_mode = 0;
        tick();
        rdy_mode = 1;
        @(negedge clk);
        chk("pre_rst_last", out_last, 1);
        chk("pre_rst_level", level, 3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_last", out_last, 0);
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
